// File: rtl/pfreq_acceptor.sv
// Prefetch request acceptor: buffers pftocache requests, drops duplicate line addresses,
// issues one lookup at a time into the tag pipe and keeps saturating prefetch statistics.
//
// state   | meaning
// IDLE    | no lookup outstanding; pops the FIFO head when one is queued
// ISSUE   | pfreq_valid high, held until the tag pipe accepts
// WAIT    | lookup accepted, waiting for pfrsp_valid
module pfreq_acceptor #(
    parameter int REQ_W   = 128,
    parameter int LADDR_W = 44,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pftocache_req_valid,
    output logic               pftocache_req_retry,
    input  logic [REQ_W-1:0]   pftocache_req,
    output logic               pfreq_valid,
    input  logic               pfreq_retry,
    output logic [REQ_W-1:0]   pfreq,
    input  logic               pfrsp_valid,
    input  logic               pfrsp_hit,
    input  logic               stats_clear,
    output logic [4*CNT_W-1:0] pf_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [REQ_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               retry_q;
    logic [REQ_W-1:0]   infl_q, infl_d;
    logic [CNT_W-1:0]   niss_q, niss_d, nhit_q, nhit_d, nmiss_q, nmiss_d, ndrop_q, ndrop_d;

    logic               xfer, dup, enq, drop, pop, issue_fire, rsp_fire;
    logic [LADDR_W-1:0] in_laddr;
    logic [AW-1:0]      wr_idx, rd_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign in_laddr = pftocache_req[LADDR_W-1:0];
    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign count_q  = wr_ptr_q - rd_ptr_q;
    assign xfer     = pftocache_req_valid & ~retry_q;

    // Compare against pre-pop contents so a copy of the head being popped is still dropped.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_q[i][LADDR_W-1:0] == in_laddr)) dup = 1'b1;
        end
        if ((state_q != S_IDLE) && (infl_q[LADDR_W-1:0] == in_laddr)) dup = 1'b1;
    end

    assign enq  = xfer & ~dup;
    assign drop = xfer & dup;

    always_comb begin
        state_d    = state_q;
        infl_d     = infl_q;
        pop        = 1'b0;
        issue_fire = 1'b0;
        rsp_fire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    infl_d  = mem_q[rd_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!pfreq_retry) begin
                    issue_fire = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pfrsp_valid) begin
                    rsp_fire = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(enq);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        vld_d    = vld_q;
        if (pop) vld_d[rd_idx] = 1'b0;
        if (enq) vld_d[wr_idx] = 1'b1;
    end

    always_comb begin
        niss_d  = niss_q;
        nhit_d  = nhit_q;
        nmiss_d = nmiss_q;
        ndrop_d = ndrop_q;
        if (stats_clear) begin
            niss_d  = '0;
            nhit_d  = '0;
            nmiss_d = '0;
            ndrop_d = '0;
        end else begin
            if (issue_fire)             niss_d  = sat_inc(niss_q);
            if (rsp_fire && pfrsp_hit)  nhit_d  = sat_inc(nhit_q);
            if (rsp_fire && !pfrsp_hit) nmiss_d = sat_inc(nmiss_q);
            if (drop)                   ndrop_d = sat_inc(ndrop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            retry_q  <= 1'b0;
            infl_q   <= '0;
            niss_q   <= '0;
            nhit_q   <= '0;
            nmiss_q  <= '0;
            ndrop_q  <= '0;
        end else begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            retry_q  <= (count_d == FULL_CNT);
            infl_q   <= infl_d;
            niss_q   <= niss_d;
            nhit_q   <= nhit_d;
            nmiss_q  <= nmiss_d;
            ndrop_q  <= ndrop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && enq) mem_q[wr_idx] <= pftocache_req;
    end

    assign pftocache_req_retry = retry_q;
    assign pfreq_valid         = (state_q == S_ISSUE);
    assign pfreq               = infl_q;
    assign pf_stats            = {niss_q, nhit_q, nmiss_q, ndrop_q};

endmodule

// File: tb/tb_pfreq_acceptor.sv
// Directed bench for pfreq_acceptor: handshake, dedup, issue order, saturation, clear, reset.
module tb_pfreq_acceptor;
    localparam int REQ_W = 128;
    localparam int CNT_W = 14;
    localparam int SMAX  = 16383;

    logic               clk = 1'b0;
    logic               reset;
    logic               pftocache_req_valid;
    logic               pftocache_req_retry;
    logic [REQ_W-1:0]   pftocache_req;
    logic               pfreq_valid;
    logic               pfreq_retry;
    logic [REQ_W-1:0]   pfreq;
    logic               pfrsp_valid;
    logic               pfrsp_hit;
    logic               stats_clear;
    logic [4*CNT_W-1:0] pf_stats;

    int vectors = 0;
    int miscompares = 0;
    int exp_iss = 0, exp_hit = 0, exp_miss = 0, exp_drop = 0;
    int n_xfer;
    bit saw;

    pfreq_acceptor dut (
        .clk                 (clk),
        .reset               (reset),
        .pftocache_req_valid (pftocache_req_valid),
        .pftocache_req_retry (pftocache_req_retry),
        .pftocache_req       (pftocache_req),
        .pfreq_valid         (pfreq_valid),
        .pfreq_retry         (pfreq_retry),
        .pfreq               (pfreq),
        .pfrsp_valid         (pfrsp_valid),
        .pfrsp_hit           (pfrsp_hit),
        .stats_clear         (stats_clear),
        .pf_stats            (pf_stats)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    function automatic logic [55:0] exp_stats();
        logic [13:0] a, b, c, d;
        a = exp_iss[13:0];
        b = exp_hit[13:0];
        c = exp_miss[13:0];
        d = exp_drop[13:0];
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] mkp(input logic [43:0] la);
        return {la ^ 44'h5a5_a5a5_a5a5, 40'hc0_ffee_1234, la};
    endfunction

    task automatic send(input logic [127:0] p);
        int n = 0;
        pftocache_req_valid = 1'b1;
        pftocache_req       = p;
        while (pftocache_req_retry && n < 40) begin
            step();
            n++;
        end
        if (pftocache_req_retry) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout: retry observed %0b expected 0", pftocache_req_retry);
        end
        step();
        pftocache_req_valid = 1'b0;
    endtask

    task automatic do_lookup(input string tag, input logic [127:0] p, input bit hit);
        int n = 0;
        pfreq_retry = 1'b0;
        while (!pfreq_valid && n < 20) begin
            step();
            n++;
        end
        if (!pfreq_valid) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_timeout: pfreq_valid observed 0 expected 1", tag);
        end else begin
            chk(tag, pfreq, p);
            step();
            exp_iss = sat(exp_iss);
            pfrsp_valid = 1'b1;
            pfrsp_hit   = hit;
            step();
            pfrsp_valid = 1'b0;
            pfrsp_hit   = 1'b0;
            if (hit) exp_hit = sat(exp_hit);
            else     exp_miss = sat(exp_miss);
        end
    endtask

    initial begin
        reset = 1'b0;
        pftocache_req_valid = 1'b0;
        pftocache_req = '0;
        pfreq_retry = 1'b0;
        pfrsp_valid = 1'b0;
        pfrsp_hit = 1'b0;
        stats_clear = 1'b0;

        // reset state
        step(); step(); step();
        chk("rst_retry", pftocache_req_retry, 0);
        chk("rst_pfreq_valid", pfreq_valid, 0);
        chk("rst_pfreq", pfreq, 0);
        chk("rst_stats", pf_stats, 0);
        reset = 1'b1;
        step();
        chk("rel_retry", pftocache_req_retry, 0);
        chk("rel_pfreq_valid", pfreq_valid, 0);
        chk("rel_stats", pf_stats, 0);

        // single request, miss; issue latency 2 cycles after acceptance
        send(mkp(44'h100));
        chk("lat1_pfreq_valid", pfreq_valid, 0);
        step();
        chk("lat2_pfreq_valid", pfreq_valid, 1);
        do_lookup("single_pfreq", mkp(44'h100), 1'b0);
        chk("single_stats", pf_stats, {14'd1, 14'd0, 14'd1, 14'd0});
        chk("single_stats_model", pf_stats, exp_stats());

        // fill: one lookup stalled in ISSUE, then six distinct back-to-back
        pfreq_retry = 1'b1;
        send(mkp(44'h300));
        n_xfer = 0;
        pftocache_req_valid = 1'b1;
        pftocache_req = mkp(44'h400);
        for (int c = 0; c < 12; c++) begin
            bit will;
            will = !pftocache_req_retry;
            step();
            if (will) begin
                n_xfer++;
                if (n_xfer < 6) pftocache_req = mkp(44'h400 + 44'(n_xfer));
            end
        end
        pftocache_req_valid = 1'b0;
        chk("fill_xfers", 128'(n_xfer), 4);
        chk("fill_retry", pftocache_req_retry, 1);
        chk("fill_hold_valid", pfreq_valid, 1);
        chk("fill_hold_payload", pfreq, mkp(44'h300));
        do_lookup("fill_order_w", mkp(44'h300), 1'b0);
        do_lookup("fill_order_0", mkp(44'h400), 1'b0);
        do_lookup("fill_order_1", mkp(44'h401), 1'b0);
        do_lookup("fill_order_2", mkp(44'h402), 1'b0);
        do_lookup("fill_order_3", mkp(44'h403), 1'b0);
        chk("fill_retry_clear", pftocache_req_retry, 0);
        chk("fill_stats", pf_stats, exp_stats());

        // duplicates: second collides with the head being popped, third with the WAIT lookup
        send(mkp(44'h200));
        send(mkp(44'h200));
        chk("dup_issue_valid", pfreq_valid, 1);
        chk("dup_issue_payload", pfreq, mkp(44'h200));
        step();
        exp_iss = sat(exp_iss);
        chk("dup_wait_valid", pfreq_valid, 0);
        send(mkp(44'h200));
        exp_drop = exp_drop + 2;
        pfrsp_valid = 1'b1;
        pfrsp_hit = 1'b1;
        step();
        pfrsp_valid = 1'b0;
        pfrsp_hit = 1'b0;
        exp_hit = sat(exp_hit);
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            saw = saw | pfreq_valid;
        end
        chk("dup_single_issue", saw, 0);
        chk("dup_stats", pf_stats, exp_stats());
        chk("dup_ndrop", pf_stats[13:0], 2);

        // nhit saturation
        pfreq_retry = 1'b0;
        pfrsp_valid = 1'b1;
        pfrsp_hit = 1'b1;
        for (int i = 0; i < SMAX - 1; i++) begin
            send(mkp(44'h10000 + 44'(i)));
            exp_iss = sat(exp_iss);
            exp_hit = sat(exp_hit);
        end
        for (int c = 0; c < 30; c++) step();
        pfrsp_valid = 1'b0;
        pfrsp_hit = 1'b0;
        chk("sat_nhit_full", pf_stats[41:28], 14'h3fff);
        chk("sat_stats_pre", pf_stats, exp_stats());
        send(mkp(44'h20000));
        do_lookup("sat_pfreq", mkp(44'h20000), 1'b1);
        chk("sat_nhit_hold", pf_stats[41:28], 14'h3fff);
        chk("sat_stats_post", pf_stats, exp_stats());

        // stats_clear in the same cycle as a completing miss
        send(mkp(44'h500));
        step();
        chk("clr_issue_valid", pfreq_valid, 1);
        step();
        pfrsp_valid = 1'b1;
        pfrsp_hit = 1'b0;
        stats_clear = 1'b1;
        step();
        pfrsp_valid = 1'b0;
        stats_clear = 1'b0;
        exp_iss = 0; exp_hit = 0; exp_miss = 0; exp_drop = 0;
        chk("clr_stats", pf_stats, 0);

        // reset in WAIT with three queued entries, plus a drop against a non-head entry
        send(mkp(44'h600));
        send(mkp(44'h601));
        send(mkp(44'h602));
        send(mkp(44'h603));
        chk("rw_in_wait", pfreq_valid, 0);
        send(mkp(44'h602));
        chk("rw_drop_queued", pf_stats, {14'd1, 14'd0, 14'd0, 14'd1});
        reset = 1'b0;
        step(); step();
        chk("rw_rst_valid", pfreq_valid, 0);
        chk("rw_rst_pfreq", pfreq, 0);
        chk("rw_rst_stats", pf_stats, 0);
        reset = 1'b1;
        step();
        chk("rw_rel_valid", pfreq_valid, 0);
        chk("rw_rel_retry", pftocache_req_retry, 0);
        chk("rw_rel_stats", pf_stats, 0);
        pfrsp_valid = 1'b1;
        pfrsp_hit = 1'b1;
        step();
        pfrsp_valid = 1'b0;
        pfrsp_hit = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            saw = saw | pfreq_valid;
        end
        chk("rw_late_rsp_stats", pf_stats, 0);
        chk("rw_no_issue", saw, 0);
        send(mkp(44'h601));
        do_lookup("rw_after_pfreq", mkp(44'h601), 1'b1);
        chk("rw_after_stats", pf_stats, {14'd1, 14'd1, 14'd0, 14'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
